// File: rtl/enet_gmii_rx_frame.sv
// GMII receive framer: strips preamble/SFD, checks FCS and length,
// streams DA..data bytes and keeps good/bad frame statistics.
module enet_gmii_rx_frame #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1522,
    parameter int CNT_W   = 32
) (
    input  logic             gmii_rx_clk,
    input  logic             rst,
    input  logic             gmii_rx_dv,
    input  logic             gmii_rx_er,
    input  logic [7:0]       gmii_rxd,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser,
    output logic             stat_good,
    output logic             stat_bad,
    output logic             stat_crc_err,
    output logic             stat_len_err,
    output logic [CNT_W-1:0] cnt_good,
    output logic [CNT_W-1:0] cnt_bad
);

    localparam int LEN_W = $clog2(MAX_LEN + 2);

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA,
        DROP
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       crc_q, crc_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              err_q, err_d;
    logic [2:0]        occ_q, occ_d;
    logic [4:0][7:0]   sr_q, sr_d;
    logic [7:0]        tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic              tuser_q, tuser_d;
    logic              good_q, good_d;
    logic              bad_q, bad_d;
    logic              crc_err_q, crc_err_d;
    logic              len_err_q, len_err_d;
    logic [CNT_W-1:0]  cnt_good_q, cnt_good_d;
    logic [CNT_W-1:0]  cnt_bad_q, cnt_bad_d;
    logic              crc_ok;
    logic              len_bad;
    logic              bad;
    logic              start;

    function automatic logic [31:0] crc_byte(
        input logic [31:0] c,
        input logic [7:0]  d
    );
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        len_d     = len_q;
        err_d     = err_q;
        occ_d     = occ_q;
        sr_d      = sr_q;
        tdata_d   = 8'h00;
        tvalid_d  = 1'b0;
        tlast_d   = 1'b0;
        tuser_d   = 1'b0;
        good_d    = 1'b0;
        bad_d     = 1'b0;
        crc_err_d = 1'b0;
        len_err_d = 1'b0;
        start     = 1'b0;
        crc_ok    = (crc_q == 32'hDEBB_20E3);
        len_bad   = (len_q < LEN_W'(MIN_LEN));
        bad       = err_q | ~crc_ok | len_bad;

        unique case (state_q)
            IDLE, PRE: begin
                if (!gmii_rx_dv) begin
                    state_d = IDLE;
                end else if (gmii_rxd == 8'h55) begin
                    state_d = PRE;
                end else if (gmii_rxd == 8'hD5) begin
                    state_d = DATA;
                    start   = 1'b1;
                end else begin
                    state_d = DROP;
                end
            end
            DATA: begin
                if (gmii_rx_dv) begin
                    crc_d = crc_byte(crc_q, gmii_rxd);
                    len_d = len_q + LEN_W'(1);
                    err_d = err_q | gmii_rx_er;
                    sr_d  = {sr_q[3:0], gmii_rxd};
                    occ_d = (occ_q == 3'd5) ? 3'd5 : occ_q + 3'd1;
                    if (occ_q == 3'd5) begin
                        tvalid_d = 1'b1;
                        tdata_d  = sr_q[4];
                    end
                    // This byte makes the frame oversize: close it out now.
                    if (len_q == LEN_W'(MAX_LEN)) begin
                        tlast_d   = 1'b1;
                        tuser_d   = 1'b1;
                        bad_d     = 1'b1;
                        len_err_d = 1'b1;
                        state_d   = DROP;
                    end
                end else begin
                    state_d = IDLE;
                    if (occ_q == 3'd5) begin
                        tvalid_d  = 1'b1;
                        tdata_d   = sr_q[4];
                        tlast_d   = 1'b1;
                        tuser_d   = bad;
                        good_d    = ~bad;
                        bad_d     = bad;
                        crc_err_d = ~crc_ok;
                        len_err_d = len_bad;
                    end else begin
                        bad_d     = 1'b1;
                        len_err_d = 1'b1;
                    end
                end
            end
            DROP: begin
                if (!gmii_rx_dv) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            crc_d = 32'hFFFF_FFFF;
            len_d = '0;
            err_d = 1'b0;
            occ_d = 3'd0;
        end

        cnt_good_d = cnt_good_q;
        if (good_q && cnt_good_q != '1) begin
            cnt_good_d = cnt_good_q + CNT_W'(1);
        end
        cnt_bad_d = cnt_bad_q;
        if (bad_q && cnt_bad_q != '1) begin
            cnt_bad_d = cnt_bad_q + CNT_W'(1);
        end
    end

    always_ff @(posedge gmii_rx_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            crc_q      <= '0;
            len_q      <= '0;
            err_q      <= 1'b0;
            occ_q      <= 3'd0;
            sr_q       <= '0;
            tdata_q    <= 8'h00;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tuser_q    <= 1'b0;
            good_q     <= 1'b0;
            bad_q      <= 1'b0;
            crc_err_q  <= 1'b0;
            len_err_q  <= 1'b0;
            cnt_good_q <= '0;
            cnt_bad_q  <= '0;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            len_q      <= len_d;
            err_q      <= err_d;
            occ_q      <= occ_d;
            sr_q       <= sr_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tuser_q    <= tuser_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            crc_err_q  <= crc_err_d;
            len_err_q  <= len_err_d;
            cnt_good_q <= cnt_good_d;
            cnt_bad_q  <= cnt_bad_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign stat_good     = good_q;
    assign stat_bad      = bad_q;
    assign stat_crc_err  = crc_err_q;
    assign stat_len_err  = len_err_q;
    assign cnt_good      = cnt_good_q;
    assign cnt_bad       = cnt_bad_q;

endmodule
